// File: rtl/peripheral_arbiter.sv
// peripheral_arbiter
// Shares the single request port of the peripheral register block between the
// processor core and the external control system. One request is captured at a
// time with round-robin fairness, issued as a one-cycle strobe, and answered
// with a one-cycle done pulse after the fixed read latency.
module peripheral_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        req_core_i,
    input  logic        rw_core_i,
    input  logic [26:0] add_core_i,
    input  logic [31:0] data_core_i,
    output logic        done_core_o,
    output logic [31:0] data_core_o,
    input  logic        req_cs_i,
    input  logic        rw_cs_i,
    input  logic [26:0] add_cs_i,
    input  logic [31:0] data_cs_i,
    output logic        done_cs_o,
    output logic [31:0] data_cs_o,
    output logic        req_per_o,
    output logic        rw_per_o,
    output logic [26:0] add_per_o,
    output logic [31:0] data_per_o,
    input  logic [31:0] data_per_i
);

    localparam logic [31:0] DATA_RESET   = 32'hDEADBEAF;
    localparam logic [3:0]  LATENCY_LOAD = 4'(READ_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        gnt;
    logic        gnt_next;
    logic        last;
    logic [3:0]  cnt;
    logic        cnt_last;

    assign cnt_last = (cnt == 4'd1);

    // Next state and arbitration: on a tie the requester not served last wins
    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        case (state)
            IDLE: begin
                if (req_core_i && req_cs_i) begin
                    gnt_next   = ~last;
                    state_next = ISSUE;
                end else if (req_core_i) begin
                    gnt_next   = 1'b0;
                    state_next = ISSUE;
                end else if (req_cs_i) begin
                    gnt_next   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = rw_per_o ? RESP : WAIT;
            WAIT:    if (cnt_last) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset drops any in-flight transaction
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant, fairness history, latency counter and the latched downstream request
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            gnt        <= 1'b0;
            last       <= 1'b1;
            cnt        <= 4'd0;
            rw_per_o   <= 1'b0;
            add_per_o  <= 27'd0;
            data_per_o <= 32'd0;
        end else begin
            gnt <= gnt_next;
            case (state)
                IDLE: begin
                    if (state_next == ISSUE) begin
                        if (gnt_next) begin
                            rw_per_o   <= rw_cs_i;
                            add_per_o  <= add_cs_i;
                            data_per_o <= data_cs_i;
                        end else begin
                            rw_per_o   <= rw_core_i;
                            add_per_o  <= add_core_i;
                            data_per_o <= data_core_i;
                        end
                    end
                end
                ISSUE:   cnt <= LATENCY_LOAD;
                WAIT:    cnt <= cnt - 4'd1;
                RESP:    last <= gnt;
                default: ;
            endcase
        end
    end

    // Registered strobes and read data returned to the granted requester
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            req_per_o   <= 1'b0;
            done_core_o <= 1'b0;
            done_cs_o   <= 1'b0;
            data_core_o <= DATA_RESET;
            data_cs_o   <= DATA_RESET;
        end else begin
            req_per_o   <= (state_next == ISSUE);
            done_core_o <= (state_next == RESP) && !gnt;
            done_cs_o   <= (state_next == RESP) && gnt;
            if ((state == WAIT) && cnt_last) begin
                if (gnt) begin
                    data_cs_o <= data_per_i;
                end else begin
                    data_core_o <= data_per_i;
                end
            end
        end
    end

endmodule
